// File: rtl/fp_mul_sequencer_if.sv
// Operand/result bus between the FP multiplier operand registers, the
// sequencer and the result bus.
//   start     : request; only sampled while the sequencer is idle
//   in1, in2  : single-precision operands A and B
//   busy      : sequencer is working on an accepted request
//   done      : one-cycle pulse; result/overflow/underflow are valid with it
//   result    : product, held until the next accepted request
//   overflow  : result saturated to infinity
//   underflow : non-zero operands produced a product flushed to zero
// master drives requests (operand side); slave is the sequencer.
interface fp_mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             underflow;

  modport master (
    output start, in1, in2,
    input  busy, done, result, overflow, underflow
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, result, overflow, underflow
  );
endinterface

// File: rtl/fp_mul_sequencer.sv
// Multi-cycle IEEE-754 single-precision multiplier: zero/infinity
// short-circuit, 24-step shift-add mantissa multiply, normalisation and
// round-to-nearest-even. Denormal operands are flushed to zero and NaN is
// treated as infinity.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fp_mul_sequencer_if (start/in1/in2 in,
//           busy/done/result/overflow/underflow out, all registered)
module fp_mul_sequencer #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned BIAS   = 127
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_mul_sequencer_if.slave   bus
);

  localparam int unsigned W  = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW = FRAC_W + 1;       // mantissa incl. hidden bit
  localparam int unsigned PW = 2 * MW;           // full product width
  localparam int unsigned EW = EXP_W + 2;        // signed working exponent
  localparam int unsigned CW = $clog2(MW);

  typedef enum logic [2:0] {StIdle, StCheck, StMult, StNorm, StRound, StDone} state_e;

  state_e                  state_q;
  logic [W-1:0]            a_q, b_q;
  logic                    sign_q;
  logic signed [EW-1:0]    e_q;
  logic [MW-1:0]           mcand_q, mplier_q;
  logic [PW-1:0]           acc_q;
  logic [CW-1:0]           cnt_q;
  logic [FRAC_W-1:0]       mant_q;
  logic                    guard_q, sticky_q;
  logic                    busy_q, done_q, ovf_q, udf_q;
  logic [W-1:0]            result_q;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

  // Operand field decode
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              sign_ab, any_zero, any_inf;
  logic signed [EW-1:0] e_sum;

  assign ea       = a_q[W-2 -: EXP_W];
  assign eb       = b_q[W-2 -: EXP_W];
  assign fa       = a_q[FRAC_W-1:0];
  assign fb       = b_q[FRAC_W-1:0];
  assign sign_ab  = a_q[W-1] ^ b_q[W-1];
  assign any_zero = (ea == '0) || (eb == '0);
  assign any_inf  = (ea == '1) || (eb == '1);
  assign e_sum    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(EW'(BIAS));

  // Shift-add step: add into the upper half, then shift the whole
  // accumulator right with the carry entering at the top.
  logic [MW:0]   add_sum;
  logic [PW-1:0] acc_next;

  always_comb begin
    add_sum  = {1'b0, acc_q[PW-1:MW]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_next = {add_sum, acc_q[MW-1:1]};
  end

  // Round-to-nearest-even; a carry out of the fraction leaves it all-zero,
  // which is exactly the renormalised 1.0 fraction.
  logic              rnd_inc;
  logic [FRAC_W:0]   mant_rnd;
  logic signed [EW-1:0] e_rnd;
  logic              rnd_ovf, rnd_udf;

  always_comb begin
    rnd_inc  = guard_q & (sticky_q | mant_q[0]);
    mant_rnd = {1'b0, mant_q} + {{FRAC_W{1'b0}}, rnd_inc};
    e_rnd    = e_q + $signed({{(EW-1){1'b0}}, mant_rnd[FRAC_W]});
    rnd_ovf  = e_rnd >= $signed({2'b00, {EXP_W{1'b1}}});
    rnd_udf  = e_rnd[EW-1] || (e_rnd == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      e_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.in1;
            b_q     <= bus.in2;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          sign_q <= sign_ab;
          if (any_zero) begin
            result_q <= {sign_ab, {(W-1){1'b0}}};
            udf_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (any_inf) begin
            result_q <= {sign_ab, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            e_q      <= e_sum;
            mcand_q  <= {1'b1, fa};
            mplier_q <= {1'b1, fb};
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StMult;
          end
        end
        StMult: begin
          acc_q    <= acc_next;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(MW - 1)) begin
            state_q <= StNorm;
          end
        end
        StNorm: begin
          if (acc_q[PW-1]) begin
            mant_q   <= acc_q[PW-2 -: FRAC_W];
            guard_q  <= acc_q[MW-1];
            sticky_q <= |acc_q[MW-2:0];
            e_q      <= e_q + $signed(EW'(1));
          end else begin
            mant_q   <= acc_q[PW-3 -: FRAC_W];
            guard_q  <= acc_q[MW-2];
            sticky_q <= |acc_q[MW-3:0];
          end
          state_q <= StRound;
        end
        StRound: begin
          if (rnd_ovf) begin
            result_q <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_q    <= 1'b1;
          end else if (rnd_udf) begin
            result_q <= {sign_q, {(W-1){1'b0}}};
            udf_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, e_rnd[EXP_W-1:0], mant_rnd[FRAC_W-1:0]};
          end
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
module tb_fp_mul_sequencer;

  logic clk;
  logic rst_n;

  fp_mul_sequencer_if bus ();

  fp_mul_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        udf;
    int          lat;   // edges after the accepting edge until done is seen
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam int LAT_NORMAL = 27;
  localparam int LAT_SHORT  = 1;

  // Present a request at a negedge; the following posedge accepts it.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic ovf, input logic udf,
                          input int lat, input string name);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    e.res = res; e.ovf = ovf; e.udf = udf; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept got %b want 1", name, bus.busy);
    end
  endtask

  // Called #1 after the accepting edge; waits for done and scores it.
  task automatic wait_done(input string name);
    exp_t e;
    int   n;
    bit   seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1) seen = 1;
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout got none want done after %0d edges", name, e.lat);
      return;
    end
    if (n != e.lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, n, e.lat);
    end
    checks++;
    if (bus.result !== e.res) begin
      errors++;
      $display("FAIL %s result got %h want %h", name, bus.result, e.res);
    end
    checks++;
    if (bus.overflow !== e.ovf || bus.underflow !== e.udf) begin
      errors++;
      $display("FAIL %s flags got ovf=%b udf=%b want ovf=%b udf=%b", name,
               bus.overflow, bus.underflow, e.ovf, e.udf);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_done got %b want 1", name, bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== e.res) begin
      errors++;
      $display("FAIL %s after_done got done=%b result=%h want done=0 result=%h", name,
               bus.done, bus.result, e.res);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs got busy=%b done=%b result=%h ovf=%b udf=%b want all 0",
               name, bus.busy, bus.done, bus.result, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    start_op(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0, LAT_NORMAL, "three_x_two");
    wait_done("three_x_two");
  endtask

  task automatic test_zero();
    start_op(32'h00000000, 32'h40490FDB, 32'h00000000, 1'b0, 1'b0, LAT_SHORT, "zero_x_pi");
    wait_done("zero_x_pi");
    start_op(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, LAT_SHORT, "negzero_x_one");
    wait_done("negzero_x_one");
  endtask

  task automatic test_round();
    start_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, LAT_NORMAL, "rne_sq");
    wait_done("rne_sq");
    start_op(32'hBF800000, 32'hBF800000, 32'h3F800000, 1'b0, 1'b0, LAT_NORMAL, "neg_one_sq");
    wait_done("neg_one_sq");
    // 1.5 * 1.5 = 2.25: exercises the P[47] normalisation path
    start_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, LAT_NORMAL, "norm_shift");
    wait_done("norm_shift");
  endtask

  task automatic test_flags();
    start_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, LAT_NORMAL, "overflow");
    wait_done("overflow");
    start_op(32'h00800001, 32'h00800001, 32'h00000000, 1'b0, 1'b1, LAT_NORMAL, "underflow");
    wait_done("underflow");
    // Flags must clear on the next accepted request
    start_op(32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b1, 1'b0, LAT_SHORT, "inf_operand");
    wait_done("inf_operand");
  endtask

  task automatic test_back_to_back();
    start_op(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0, LAT_NORMAL, "busy_first");
    // Hold a second request throughout; it must wait until after DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 32'h7F000000;
    bus.in2   = 32'h7F000000;
    wait_done("busy_first");
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done busy got %b want 0", bus.busy);
    end
    begin
      exp_t e;
      e.res = 32'h7F800000; e.ovf = 1'b1; e.udf = 1'b0; e.lat = LAT_NORMAL;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL second_accept busy got %b want 1", bus.busy);
    end
    wait_done("busy_second");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    start_op(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0, LAT_NORMAL, "aborted");
    // One edge into MULT after CHECK, then ten MULT cycles
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL no_done_after_reset got done=1 want 0");
    end
    check_all_zero("idle_after_mid_reset");
    start_op(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0, LAT_NORMAL, "after_reset");
    wait_done("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_round();
    test_flags();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
